level_digit_font: RTL and testbench

- Registered decimal-digit glyph ROM for the on-screen HUD (level, score, target and chance counters).
- Converts a digit code into a 9-row x 16-pixel bitmap packed into 144 bits.
- The display line engine splices one 16-bit row per scanline into the frame line.
- Four instances are used, one per HUD counter.

---
 rtl/level_digit_font_pkg.sv | 40 ++++
 rtl/level_digit_font.sv | 33 +++
 tb/tb_level_digit_font.sv | 135 +++++++++++++
 3 files changed

// File: rtl/level_digit_font_pkg.sv
// Shared geometry constants and the 5-bit digit glyph table for the HUD digit font.
// Each digit entry packs its seven 5-bit row patterns with row 0 in the top bits.
package level_digit_font_pkg;

    localparam int GLYPH_ROWS     = 9;
    localparam int GLYPH_W        = 16;
    localparam int GLYPH_BITS     = GLYPH_ROWS * GLYPH_W;
    localparam int DIGIT_ROWS     = 7;
    localparam int BLANK_CODE_MIN = 10;
    localparam int PATTERN_W      = 5;

    typedef logic [PATTERN_W-1:0]            pattern_t;
    typedef logic [DIGIT_ROWS*PATTERN_W-1:0] digit_glyph_t;

    localparam digit_glyph_t DIGIT_TABLE [BLANK_CODE_MIN] = '{
        {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E},  // 0
        {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E},  // 1
        {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F},  // 2
        {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E},  // 3
        {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02},  // 4
        {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E},  // 5
        {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E},  // 6
        {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08},  // 7
        {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E},  // 8
        {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C}   // 9
    };

    // Pattern for digit row k (0..6); any code outside 0..9 yields a blank row.
    function automatic pattern_t digit_pattern(input logic [4:0] digit, input int row);
        digit_glyph_t glyph;
        pattern_t     pat;
        pat = '0;
        if (int'(digit) < BLANK_CODE_MIN && row >= 0 && row < DIGIT_ROWS) begin
            glyph = DIGIT_TABLE[int'(digit)];
            pat   = glyph[(DIGIT_ROWS-row)*PATTERN_W-1 -: PATTERN_W];
        end
        return pat;
    endfunction

endpackage

// File: rtl/level_digit_font.sv
// Registered decimal-digit glyph ROM: digit code in, 9x16 bitmap out one cycle later.
// Rows 0 and 8 stay blank; rows 1..7 carry the 5-pixel pattern shifted by COL_SHIFT.
module level_digit_font
    import level_digit_font_pkg::*;
#(
    parameter int COL_SHIFT = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4:0]            level_num,
    output logic [GLYPH_BITS-1:0] data
);

    logic [GLYPH_BITS-1:0] glyph;

    always_comb begin
        glyph = '0;
        for (int r = 1; r <= DIGIT_ROWS; r++) begin
            glyph[GLYPH_BITS-1-GLYPH_W*r -: GLYPH_W] =
                GLYPH_W'(digit_pattern(level_num, r - 1)) << COL_SHIFT;
        end
    end

    // NOTE: registered state uses non-blocking assignment so every reader sees the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else begin
            data <= glyph;
        end
    end

endmodule

// File: tb/tb_level_digit_font.sv
// Directed bench for level_digit_font: reset, digit rows, latency, sweep, blank codes, async reset.
module tb_level_digit_font;

    logic         clk;
    logic         rst_n;
    logic [4:0]   level_num;
    logic [143:0] data;

    int passed = 0;
    int total  = 0;

    level_digit_font dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .level_num (level_num),
        .data      (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written digit patterns; the expected row is pattern << 6.
    logic [4:0] pat [10][7] = '{
        '{5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E},
        '{5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E},
        '{5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F},
        '{5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E},
        '{5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02},
        '{5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E},
        '{5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E},
        '{5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08},
        '{5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E},
        '{5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C}
    };

    function automatic logic [15:0] row_of(input logic [143:0] d, input int r);
        return d[143-16*r -: 16];
    endfunction

    function automatic logic [143:0] expected_glyph(input int digit);
        logic [143:0] g;
        logic [15:0]  w;
        g = '0;
        for (int r = 1; r <= 7; r++) begin
            w = {11'b0, pat[digit][r-1]};
            g[143-16*r -: 16] = w << 6;
        end
        return g;
    endfunction

    task automatic check(input string tag, input logic [143:0] observed, input logic [143:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] zero_or;
        logic [15:0] rsv_or;
        logic [143:0] d0;

        // Reset held with a valid digit on the input.
        rst_n     = 1'b0;
        level_num = 5'd8;
        repeat (3) tick();
        check("reset_zero", data, 144'h0);
        #2 rst_n = 1'b1;
        tick();
        check("post_reset_row4", 144'(row_of(data, 4)), 144'h0380);
        check("post_reset_row1", 144'(row_of(data, 1)), 144'h0380);
        check("post_reset_row2", 144'(row_of(data, 2)), 144'h0440);

        // Digit 0, full bitmap written out by hand.
        level_num = 5'd0;
        tick();
        d0 = {16'h0000, 16'h0380, 16'h0440, 16'h04C0, 16'h0540,
              16'h0640, 16'h0440, 16'h0380, 16'h0000};
        check("digit0_full", data, d0);

        // Latency: input change right after an edge is invisible until the next edge.
        level_num = 5'd1;
        tick();
        level_num = 5'd7;
        #3;
        check("latency_hold_row1", 144'(row_of(data, 1)), 144'h0100);
        tick();
        check("latency_new_row1", 144'(row_of(data, 1)), 144'h07C0);
        check("latency_new_row7", 144'(row_of(data, 7)), 144'h0200);

        // Back-to-back sweep: each result reflects the digit applied one edge earlier.
        for (int d = 0; d <= 9; d++) begin
            level_num = 5'(d);
            tick();
            check($sformatf("sweep_digit%0d", d), data, expected_glyph(d));
            zero_or = row_of(data, 0) | row_of(data, 8);
            rsv_or  = '0;
            for (int r = 0; r < 9; r++) rsv_or |= row_of(data, r) & 16'hF83F;
            check($sformatf("sweep_blank_bits%0d", d), 144'({zero_or, rsv_or}), 144'h0);
        end

        // Out-of-range codes give a blank glyph.
        level_num = 5'd10;
        tick();
        check("blank_10", data, 144'h0);
        level_num = 5'd15;
        tick();
        check("blank_15", data, 144'h0);
        level_num = 5'd31;
        tick();
        check("blank_31", data, 144'h0);
        level_num = 5'd9;
        tick();
        check("return_9_row4", 144'(row_of(data, 4)), 144'h03C0);

        // Asynchronous reset between edges while showing 5.
        level_num = 5'd5;
        tick();
        check("digit5_before_reset", data, expected_glyph(5));
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_clear", data, 144'h0);
        #1 rst_n = 1'b1;
        tick();
        check("after_async_row1", 144'(row_of(data, 1)), 144'h07C0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
